// File: rtl/bitstream_packer.sv
// Packs right-aligned variable-length codewords into an MSB-first stream of
// 32-bit words, with a flush that zero-pads the trailing partial word.
module bitstream_packer (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        CODE_VALID,
  output logic        CODE_READY,
  input  logic [23:0] CODE_BITS,
  input  logic [4:0]  CODE_LENGTH,
  input  logic        FLUSH,
  output logic        FLUSH_DONE,
  output logic        WORD_VALID,
  input  logic        WORD_READY,
  output logic [31:0] WORD_DATA,
  output logic [31:0] TOTAL_BITS,
  output logic        LENGTH_ERR
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t      state_q, state_d;
  logic [55:0] acc_q, acc_d;
  logic [5:0]  fill_q, fill_d;
  logic [31:0] total_q, total_d;
  logic        len_err_q, len_err_d;

  logic        accept, transfer, len_ok;
  logic [24:0] mask;
  logic [23:0] masked_code;
  logic [5:0]  shamt;
  logic [55:0] code_placed;

  // State register
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q   <= RUN;
      acc_q     <= '0;
      fill_q    <= '0;
      total_q   <= '0;
      len_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fill_q    <= fill_d;
      total_q   <= total_d;
      len_err_q <= len_err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (FLUSH) state_d = DRAIN;
      DRAIN:   if (fill_q == 6'd0) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output logic; everything is held low while RESET is asserted
  always_comb begin
    CODE_READY = 1'b0;
    WORD_VALID = 1'b0;
    FLUSH_DONE = 1'b0;
    if (!RESET) begin
      CODE_READY = (state_q == RUN) && (fill_q < 6'd32);
      WORD_VALID = (fill_q >= 6'd32) || ((state_q == DRAIN) && (fill_q != 6'd0));
      FLUSH_DONE = (state_q == DRAIN) && (fill_q == 6'd0);
    end
  end

  assign WORD_DATA  = acc_q[55:24];
  assign TOTAL_BITS = total_q;
  assign LENGTH_ERR = len_err_q;

  assign accept      = CODE_VALID && CODE_READY;
  assign transfer    = WORD_VALID && WORD_READY;
  assign len_ok      = (CODE_LENGTH <= 5'd24);
  assign mask        = (25'd1 << CODE_LENGTH) - 25'd1;
  assign masked_code = CODE_BITS & mask[23:0];
  // Left shift that lands the code's LSB at bit 56-fill-len; fill+len <= 55 at accept
  assign shamt       = 6'd56 - fill_q - {1'b0, CODE_LENGTH};
  assign code_placed = {32'd0, masked_code} << shamt;

  // Datapath: accept and transfer are mutually exclusive because CODE_READY
  // is low whenever a full word is waiting.
  always_comb begin
    acc_d     = acc_q;
    fill_d    = fill_q;
    total_d   = total_q;
    len_err_d = len_err_q;
    if (transfer) begin
      acc_d  = {acc_q[23:0], 32'd0};
      fill_d = (fill_q >= 6'd32) ? (fill_q - 6'd32) : 6'd0;
    end else if (accept) begin
      if (!len_ok) begin
        len_err_d = 1'b1;
      end else if (CODE_LENGTH != 5'd0) begin
        acc_d   = acc_q | code_placed;
        fill_d  = fill_q + {1'b0, CODE_LENGTH};
        total_d = total_q + {27'd0, CODE_LENGTH};
      end
    end
  end

endmodule

// File: tb/tb_bitstream_packer.sv
// Directed bench for bitstream_packer: a vector table for the main stream,
// plus hand-written reset, backpressure and mid-drain reset sequences.
module tb_bitstream_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        code_valid;
  logic        code_ready;
  logic [23:0] code_bits;
  logic [4:0]  code_length;
  logic        flush;
  logic        flush_done;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [31:0] total_bits;
  logic        length_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bitstream_packer dut (
    .CLOCK      (clk),
    .RESET      (rst),
    .CODE_VALID (code_valid),
    .CODE_READY (code_ready),
    .CODE_BITS  (code_bits),
    .CODE_LENGTH(code_length),
    .FLUSH      (flush),
    .FLUSH_DONE (flush_done),
    .WORD_VALID (word_valid),
    .WORD_READY (word_ready),
    .WORD_DATA  (word_data),
    .TOTAL_BITS (total_bits),
    .LENGTH_ERR (length_err)
  );

  typedef struct {
    logic        v;
    logic [23:0] bits;
    logic [4:0]  len;
    logic        fl;
    logic        wr;
    logic        wv;
    logic [31:0] wd;
    logic        cr;
    logic        fd;
    logic [31:0] tot;
    logic        le;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic v, input logic [23:0] bits, input logic [4:0] len,
                     input logic fl, input logic wr, input logic wv, input logic [31:0] wd,
                     input logic cr, input logic fd, input logic [31:0] tot, input logic le);
    vec_t t;
    t.v = v; t.bits = bits; t.len = len; t.fl = fl; t.wr = wr;
    t.wv = wv; t.wd = wd; t.cr = cr; t.fd = fd; t.tot = tot; t.le = le;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [23:0] bits, input logic [4:0] len,
                       input logic fl, input logic wr);
    code_valid = v; code_bits = bits; code_length = len; flush = fl; word_ready = wr;
  endtask

  initial begin
    // Reset held 3 cycles with a codeword offered
    rst = 1'b1;
    drive(1'b1, 24'hFFFFFF, 5'd24, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_cready", {31'd0, code_ready}, 32'd0);
      check("rst_wvalid", {31'd0, word_valid}, 32'd0);
      check("rst_wdata", word_data, 32'd0);
      check("rst_fdone", {31'd0, flush_done}, 32'd0);
      check("rst_total", total_bits, 32'd0);
      check("rst_lerr", {31'd0, length_err}, 32'd0);
      $display("reset cycle %0d: cready=%b wvalid=%b total=%0d", i, code_ready, word_valid, total_bits);
    end
    rst = 1'b0;
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("rel_cready", {31'd0, code_ready}, 32'd1);
    check("rel_total", total_bits, 32'd0);

    //   v  bits        len    fl wr   wv  wd            cr fd  tot  le
    add(1, 24'h00ABCD, 5'd16, 0, 1,   0, 32'h00000000, 1, 0, 32'd0,  0);
    add(1, 24'h001234, 5'd16, 0, 1,   0, 32'hABCD0000, 1, 0, 32'd16, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   1, 32'hABCD1234, 0, 0, 32'd32, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 1, 0, 32'd32, 0);
    add(1, 24'hFFFFFF, 5'd24, 0, 1,   0, 32'h00000000, 1, 0, 32'd32, 0);
    add(1, 24'h000ABC, 5'd12, 0, 1,   0, 32'hFFFFFF00, 1, 0, 32'd56, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   1, 32'hFFFFFFAB, 0, 0, 32'd68, 0);
    add(0, 24'h000000, 5'd0,  1, 0,   0, 32'hC0000000, 1, 0, 32'd68, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   1, 32'hC0000000, 0, 0, 32'd68, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 0, 1, 32'd68, 0);
    add(1, 24'hFFFFFF, 5'd0,  0, 1,   0, 32'h00000000, 1, 0, 32'd68, 0);
    add(1, 24'hFFFFF5, 5'd4,  0, 1,   0, 32'h00000000, 1, 0, 32'd68, 0);
    add(1, 24'hFFFFFF, 5'd25, 0, 1,   0, 32'h50000000, 1, 0, 32'd72, 0);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h50000000, 1, 0, 32'd72, 1);
    add(1, 24'h7FFFFF, 5'd31, 0, 1,   0, 32'h50000000, 1, 0, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  1, 1,   0, 32'h50000000, 1, 0, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   1, 32'h50000000, 0, 0, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 0, 1, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  1, 1,   0, 32'h00000000, 1, 0, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 0, 1, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 1, 0, 32'd72, 1);
    add(1, 24'h000001, 5'd1,  1, 1,   0, 32'h00000000, 1, 0, 32'd72, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   1, 32'h80000000, 0, 0, 32'd73, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 0, 1, 32'd73, 1);
    add(0, 24'h000000, 5'd0,  0, 1,   0, 32'h00000000, 1, 0, 32'd73, 1);

    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].bits, vecs[i].len, vecs[i].fl, vecs[i].wr);
      #1;
      check($sformatf("v%0d_wvalid", i), {31'd0, word_valid}, {31'd0, vecs[i].wv});
      check($sformatf("v%0d_wdata", i), word_data, vecs[i].wd);
      check($sformatf("v%0d_cready", i), {31'd0, code_ready}, {31'd0, vecs[i].cr});
      check($sformatf("v%0d_fdone", i), {31'd0, flush_done}, {31'd0, vecs[i].fd});
      check($sformatf("v%0d_total", i), total_bits, vecs[i].tot);
      check($sformatf("v%0d_lerr", i), {31'd0, length_err}, {31'd0, vecs[i].le});
      $display("vec %0d: v=%b bits=%h len=%0d fl=%b wr=%b -> wv=%b wd=%h cr=%b fd=%b tot=%0d le=%b",
               i, vecs[i].v, vecs[i].bits, vecs[i].len, vecs[i].fl, vecs[i].wr,
               word_valid, word_data, code_ready, flush_done, total_bits, length_err);
      tick();
    end

    // Backpressure: fresh reset, 48 bits pending with consumer stalled
    rst = 1'b1;
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b0);
    tick();
    rst = 1'b0;
    check("bp_lerr_cleared", {31'd0, length_err}, 32'd0);
    drive(1'b1, 24'h123456, 5'd24, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'h789ABC, 5'd24, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'hFFFFFF, 5'd24, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_wvalid", {31'd0, word_valid}, 32'd1);
      check("bp_wdata", word_data, 32'h12345678);
      check("bp_cready", {31'd0, code_ready}, 32'd0);
      $display("backpressure cycle %0d: wv=%b wd=%h cr=%b", i, word_valid, word_data, code_ready);
      tick();
    end
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    tick();
    check("bp_after_wvalid", {31'd0, word_valid}, 32'd0);
    check("bp_after_wdata", word_data, 32'h9ABC0000);
    drive(1'b1, 24'h00DEF0, 5'd16, 1'b0, 1'b1);
    tick();
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("bp_next_wvalid", {31'd0, word_valid}, 32'd1);
    check("bp_next_wdata", word_data, 32'h9ABCDEF0);
    check("bp_total", total_bits, 32'd64);
    $display("backpressure release: wd=%h total=%0d", word_data, total_bits);
    tick();

    // Mid-drain reset: 40 bits pending, FLUSH, then reset while stalled
    drive(1'b1, 24'hAAAAAA, 5'd24, 1'b0, 1'b0);
    tick();
    drive(1'b1, 24'hBBBBBB, 5'd16, 1'b0, 1'b0);
    tick();
    drive(1'b0, 24'd0, 5'd0, 1'b1, 1'b0);
    #1;
    check("md_wdata", word_data, 32'hAAAAAABB);
    tick();
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b0);
    #1;
    check("md_drain_wvalid", {31'd0, word_valid}, 32'd1);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("md_rst_fdone", {31'd0, flush_done}, 32'd0);
      tick();
    end
    rst = 1'b0;
    #1;
    check("md_rel_fdone", {31'd0, flush_done}, 32'd0);
    check("md_rel_wvalid", {31'd0, word_valid}, 32'd0);
    check("md_rel_wdata", word_data, 32'd0);
    check("md_rel_total", total_bits, 32'd0);
    check("md_rel_cready", {31'd0, code_ready}, 32'd1);
    $display("mid-drain reset release: wv=%b fd=%b total=%0d", word_valid, flush_done, total_bits);
    // A fresh 32 bits must form an exact word, proving fill restarted at 0
    drive(1'b1, 24'h00CAFE, 5'd16, 1'b0, 1'b1);
    tick();
    drive(1'b1, 24'h00F00D, 5'd16, 1'b0, 1'b1);
    tick();
    drive(1'b0, 24'd0, 5'd0, 1'b0, 1'b1);
    #1;
    check("md_fresh_wvalid", {31'd0, word_valid}, 32'd1);
    check("md_fresh_wdata", word_data, 32'hCAFEF00D);
    check("md_fresh_fdone", {31'd0, flush_done}, 32'd0);
    $display("post-reset word: wd=%h", word_data);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
